// File: rtl/iir_servo_sequencer_if.sv
// Host-side register bus of the servo sequencer: shadow tap writes, commit
// request, and the commit status returned to the host.
interface iir_servo_sequencer_if;
   logic [1:0]         coef_addr_in;
   logic signed [34:0] coef_data_in;
   logic               coef_we_in;
   logic               commit_in;
   logic               busy_out;
   logic               commit_done_out;

   modport master (
      output coef_addr_in, coef_data_in, coef_we_in, commit_in,
      input  busy_out, commit_done_out
   );

   modport slave (
      input  coef_addr_in, coef_data_in, coef_we_in, commit_in,
      output busy_out, commit_done_out
   );
endinterface

// File: rtl/iir_servo_sequencer.sv
// Control-plane sequencer for a first-order IIR servo: primes the filter under
// hold at start-up and swaps shadow taps into the active set atomically under hold.
module iir_servo_sequencer #(
   parameter int SIGNAL_OUT_SIZE = 16,
   parameter int SETTLE_CYCLES   = 4
) (
   input  logic                               clk_in,
   input  logic                               rst_in,
   iir_servo_sequencer_if.slave               host,
   input  logic                               enable_in,
   input  logic                               hold_req_in,
   input  logic signed [SIGNAL_OUT_SIZE-1:0]  filter_out_in,
   input  logic signed [SIGNAL_OUT_SIZE-1:0]  rail_hi_in,
   input  logic signed [SIGNAL_OUT_SIZE-1:0]  rail_lo_in,
   output logic signed [34:0]                 a1_out,
   output logic signed [34:0]                 b0_out,
   output logic signed [34:0]                 b1_out,
   output logic                               on_out,
   output logic                               hold_out,
   output logic [1:0]                         railed_out,
   output logic [1:0]                         state_out
);

   localparam int         COEF_W      = 35;
   localparam logic [4:0] SETTLE_LAST = 5'(SETTLE_CYCLES - 1);
   localparam logic [4:0] SETTLE_FULL = 5'(SETTLE_CYCLES);

   typedef enum logic [1:0] {
      OFF    = 2'd0,
      PRIME  = 2'd1,
      RUN    = 2'd2,
      UPDATE = 2'd3
   } state_t;

   state_t                    state, state_nxt;
   logic [4:0]                cnt, cnt_nxt;
   logic                      pending, pending_nxt;
   logic                      copy_en;
   logic                      done_nxt;
   logic                      done_r;
   logic                      hold_req_d;
   logic [1:0]                railed_nxt;
   logic signed [COEF_W-1:0]  a1_sh, b0_sh, b1_sh;
   logic signed [COEF_W-1:0]  a1_act, b0_act, b1_act;

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state      <= OFF;
         cnt        <= '0;
         pending    <= 1'b0;
         done_r     <= 1'b0;
         hold_req_d <= 1'b0;
         railed_out <= 2'b00;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         pending    <= pending_nxt;
         done_r     <= done_nxt;
         hold_req_d <= hold_req_in;
         railed_out <= railed_nxt;
      end
   end

   // Disable wins over everything; a commit not yet copied is simply dropped.
   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      pending_nxt = pending;
      copy_en     = 1'b0;
      done_nxt    = 1'b0;
      case (state)
         OFF: begin
            pending_nxt = 1'b0;
            if (host.commit_in) begin
               copy_en  = 1'b1;
               done_nxt = 1'b1;
            end
            if (enable_in) begin
               state_nxt = PRIME;
               cnt_nxt   = SETTLE_LAST;
            end
         end
         PRIME: begin
            if (!enable_in) begin
               state_nxt   = OFF;
               pending_nxt = 1'b0;
            end else begin
               if (host.commit_in) pending_nxt = 1'b1;
               if (cnt == 5'd0) state_nxt = RUN;
               else             cnt_nxt   = cnt - 5'd1;
            end
         end
         RUN: begin
            if (!enable_in) begin
               state_nxt   = OFF;
               pending_nxt = 1'b0;
            end else if (host.commit_in || pending) begin
               state_nxt   = UPDATE;
               cnt_nxt     = SETTLE_FULL;
               pending_nxt = 1'b0;
            end
         end
         UPDATE: begin
            if (!enable_in) begin
               state_nxt   = OFF;
               pending_nxt = 1'b0;
            end else begin
               if (cnt == SETTLE_FULL) copy_en = 1'b1;
               if (cnt == 5'd0) begin
                  state_nxt = RUN;
                  done_nxt  = 1'b1;
               end else begin
                  cnt_nxt = cnt - 5'd1;
               end
            end
         end
         default: state_nxt = OFF;
      endcase
   end

   // Flags are cleared whenever the filter is about to be switched off.
   always_comb begin
      railed_nxt = 2'b00;
      if (state_nxt != OFF) begin
         railed_nxt[1] = (filter_out_in >= rail_hi_in);
         railed_nxt[0] = (filter_out_in <= rail_lo_in);
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         a1_sh <= '0;
         b0_sh <= '0;
         b1_sh <= '0;
      end else if (host.coef_we_in) begin
         case (host.coef_addr_in)
            2'd0:    a1_sh <= host.coef_data_in;
            2'd1:    b0_sh <= host.coef_data_in;
            2'd2:    b1_sh <= host.coef_data_in;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         a1_act <= '0;
         b0_act <= '0;
         b1_act <= '0;
      end else if (copy_en) begin
         a1_act <= a1_sh;
         b0_act <= b0_sh;
         b1_act <= b1_sh;
      end
   end

   assign a1_out               = a1_act;
   assign b0_out               = b0_act;
   assign b1_out               = b1_act;
   assign on_out               = (state != OFF);
   assign hold_out             = (state == PRIME) || (state == UPDATE) ||
                                 ((state == RUN) && hold_req_d);
   assign state_out            = state;
   assign host.busy_out        = (state == UPDATE) || pending;
   assign host.commit_done_out = done_r;

endmodule

// File: tb/tb_iir_servo_sequencer.sv
// Directed bench for the IIR servo sequencer: reset, OFF commit, start-up,
// RUN commit, PRIME deferral, aborts, rail flags and async reset mid-update.
module tb_iir_servo_sequencer;

   logic               clk_in;
   logic               rst_in;
   logic               enable_in;
   logic               hold_req_in;
   logic signed [15:0] filter_out_in;
   logic signed [15:0] rail_hi_in;
   logic signed [15:0] rail_lo_in;
   logic signed [34:0] a1_out, b0_out, b1_out;
   logic               on_out, hold_out;
   logic [1:0]         railed_out;
   logic [1:0]         state_out;

   int vectors;
   int errors;

   localparam logic signed [34:0] A1_V  = 35'sh100_0000;
   localparam logic signed [34:0] B0_V  = 35'sh40_0000;
   localparam logic signed [34:0] B1_V  = -35'sh40_0000;
   localparam logic signed [34:0] B0_V2 = 35'sh12_3456;
   localparam logic signed [34:0] B1_V2 = 35'sh777;
   localparam logic signed [34:0] A1_V2 = 35'sh55;
   localparam logic signed [34:0] ZERO  = 35'sh0;

   iir_servo_sequencer_if host_bus ();

   iir_servo_sequencer #(
      .SIGNAL_OUT_SIZE (16),
      .SETTLE_CYCLES   (4)
   ) dut (
      .clk_in        (clk_in),
      .rst_in        (rst_in),
      .host          (host_bus),
      .enable_in     (enable_in),
      .hold_req_in   (hold_req_in),
      .filter_out_in (filter_out_in),
      .rail_hi_in    (rail_hi_in),
      .rail_lo_in    (rail_lo_in),
      .a1_out        (a1_out),
      .b0_out        (b0_out),
      .b1_out        (b1_out),
      .on_out        (on_out),
      .hold_out      (hold_out),
      .railed_out    (railed_out),
      .state_out     (state_out)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [1:0] addr, input logic signed [34:0] data);
      host_bus.coef_we_in   = 1'b1;
      host_bus.coef_addr_in = addr;
      host_bus.coef_data_in = data;
      tick();
      host_bus.coef_we_in   = 1'b0;
   endtask

   initial begin
      vectors = 0;
      errors  = 0;
      rst_in                = 1'b1;
      enable_in             = 1'b0;
      hold_req_in           = 1'b0;
      filter_out_in         = '0;
      rail_hi_in            = 16'sd1000;
      rail_lo_in            = -16'sd1000;
      host_bus.coef_addr_in = '0;
      host_bus.coef_data_in = '0;
      host_bus.coef_we_in   = 1'b0;
      host_bus.commit_in    = 1'b0;
      tick();
      tick();
      chk("rst_state", state_out, 2'd0);
      chk("rst_on", on_out, 1'b0);
      chk("rst_hold", hold_out, 1'b0);
      chk("rst_railed", railed_out, 2'b00);
      chk("rst_busy", host_bus.busy_out, 1'b0);
      chk("rst_done", host_bus.commit_done_out, 1'b0);
      chk("rst_a1", a1_out, ZERO);
      rst_in = 1'b0;
      tick();

      // OFF commit
      wr(2'd0, A1_V);
      wr(2'd1, B0_V);
      wr(2'd2, B1_V);
      wr(2'd3, 35'sh3ff);
      chk("off_pre_a1", a1_out, ZERO);
      host_bus.commit_in = 1'b1;
      tick();
      host_bus.commit_in = 1'b0;
      chk("off_a1", a1_out, A1_V);
      chk("off_b0", b0_out, B0_V);
      chk("off_b1", b1_out, B1_V);
      chk("off_done", host_bus.commit_done_out, 1'b1);
      tick();
      chk("off_done_once", host_bus.commit_done_out, 1'b0);

      // Rails forced low while OFF
      filter_out_in = 16'sd1000;
      tick();
      chk("off_railed", railed_out, 2'b00);

      // Start-up
      enable_in = 1'b1;
      tick();
      for (int i = 0; i < 4; i++) begin
         chk("prime_state", state_out, 2'd1);
         chk("prime_on", on_out, 1'b1);
         chk("prime_hold", hold_out, 1'b1);
         tick();
      end
      chk("run_state", state_out, 2'd2);
      chk("run_hold0", hold_out, 1'b0);
      hold_req_in = 1'b1;
      chk("run_hold_lag", hold_out, 1'b0);
      tick();
      chk("run_hold1", hold_out, 1'b1);
      hold_req_in = 1'b0;
      tick();
      chk("run_hold_rel", hold_out, 1'b0);

      // Rails in RUN
      chk("rail_1000", railed_out, 2'b10);
      filter_out_in = 16'sd999;
      tick();
      chk("rail_999", railed_out, 2'b00);
      filter_out_in = -16'sd1000;
      tick();
      chk("rail_m1000", railed_out, 2'b01);
      filter_out_in = -16'sd1001;
      tick();
      chk("rail_m1001", railed_out, 2'b01);
      rail_hi_in    = -16'sd5;
      rail_lo_in    = 16'sd5;
      filter_out_in = 16'sd0;
      tick();
      chk("rail_inverted", railed_out, 2'b11);
      rail_hi_in = 16'sd1000;
      rail_lo_in = -16'sd1000;
      tick();
      chk("rail_mid", railed_out, 2'b00);

      // RUN commit
      wr(2'd1, B0_V2);
      host_bus.commit_in = 1'b1;
      tick();
      host_bus.commit_in = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk("upd_state", state_out, 2'd3);
         chk("upd_hold", hold_out, 1'b1);
         chk("upd_busy", host_bus.busy_out, 1'b1);
         chk("upd_done", host_bus.commit_done_out, 1'b0);
         chk("upd_b0", b0_out, (i == 0) ? B0_V : B0_V2);
         tick();
      end
      chk("upd_end_state", state_out, 2'd2);
      chk("upd_end_done", host_bus.commit_done_out, 1'b1);
      chk("upd_end_hold", hold_out, 1'b0);
      chk("upd_end_busy", host_bus.busy_out, 1'b0);
      tick();
      chk("upd_done_once", host_bus.commit_done_out, 1'b0);

      // Disable: railed cleared as filter goes off
      filter_out_in = 16'sd2000;
      enable_in = 1'b0;
      tick();
      chk("dis_state", state_out, 2'd0);
      chk("dis_on", on_out, 1'b0);
      chk("dis_railed", railed_out, 2'b00);

      // PRIME commit deferral
      enable_in = 1'b1;
      tick();
      host_bus.commit_in    = 1'b1;
      host_bus.coef_we_in   = 1'b1;
      host_bus.coef_addr_in = 2'd2;
      host_bus.coef_data_in = B1_V2;
      tick();
      host_bus.commit_in  = 1'b0;
      host_bus.coef_we_in = 1'b0;
      chk("defer_state", state_out, 2'd1);
      chk("defer_busy", host_bus.busy_out, 1'b1);
      tick();
      tick();
      tick();
      chk("defer_run", state_out, 2'd2);
      chk("defer_run_busy", host_bus.busy_out, 1'b1);
      tick();
      for (int i = 0; i < 5; i++) begin
         chk("defer_upd_state", state_out, 2'd3);
         chk("defer_upd_busy", host_bus.busy_out, 1'b1);
         tick();
      end
      chk("defer_end_state", state_out, 2'd2);
      chk("defer_end_busy", host_bus.busy_out, 1'b0);
      chk("defer_end_done", host_bus.commit_done_out, 1'b1);
      chk("defer_b1", b1_out, B1_V2);

      // Abort in first UPDATE cycle
      wr(2'd0, A1_V2);
      host_bus.commit_in = 1'b1;
      tick();
      host_bus.commit_in = 1'b0;
      chk("ab1_upd", state_out, 2'd3);
      enable_in = 1'b0;
      tick();
      chk("ab1_state", state_out, 2'd0);
      chk("ab1_on", on_out, 1'b0);
      chk("ab1_a1", a1_out, A1_V);
      chk("ab1_done", host_bus.commit_done_out, 1'b0);
      tick();
      chk("ab1_done_late", host_bus.commit_done_out, 1'b0);

      // Abort in third UPDATE cycle
      enable_in = 1'b1;
      tick();
      for (int i = 0; i < 4; i++) tick();
      chk("ab3_run", state_out, 2'd2);
      host_bus.commit_in = 1'b1;
      tick();
      host_bus.commit_in = 1'b0;
      tick();
      tick();
      chk("ab3_upd", state_out, 2'd3);
      enable_in = 1'b0;
      tick();
      chk("ab3_state", state_out, 2'd0);
      chk("ab3_a1", a1_out, A1_V2);
      chk("ab3_done", host_bus.commit_done_out, 1'b0);
      tick();
      chk("ab3_done_late", host_bus.commit_done_out, 1'b0);

      // Async reset mid-UPDATE
      enable_in = 1'b1;
      tick();
      for (int i = 0; i < 4; i++) tick();
      host_bus.commit_in = 1'b1;
      tick();
      host_bus.commit_in = 1'b0;
      tick();
      chk("ar_upd", state_out, 2'd3);
      #2;
      rst_in = 1'b1;
      #1;
      chk("ar_state", state_out, 2'd0);
      chk("ar_a1", a1_out, ZERO);
      chk("ar_b0", b0_out, ZERO);
      chk("ar_on", on_out, 1'b0);
      chk("ar_done", host_bus.commit_done_out, 1'b0);
      enable_in = 1'b0;
      tick();
      rst_in = 1'b0;
      tick();
      chk("ar_after_done", host_bus.commit_done_out, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/iir_servo_sequencer.md
# iir_servo_sequencer

Control-plane sequencer for one first-order anti-windup IIR servo filter. Holds shadow and active copies of the a1/b0/b1 taps and drives the filter's `on`, `hold` and `railed` inputs. Sequences filter start-up, so the 2-cycle input pipeline fills under hold before the integrator runs. Swaps tap sets atomically under hold, so the filter never mixes old and new taps. Sits between the host register interface and the filter instance.

## Interface
Parameters:
- `SIGNAL_OUT_SIZE`, 16: width of the filter output being monitored.
- `SETTLE_CYCLES`, 4: hold length after start-up and after each tap swap. Must be ≥ 2.

Ports:
- `clk_in`  in  1  single clock; all state on the rising edge.
- `rst_in`  in  1  asynchronous, active-high reset.
- `coef_addr_in`  in  2  shadow select: 0=a1, 1=b0, 2=b1, 3=ignored.
- `coef_data_in`  in  35 signed  shadow write data.
- `coef_we_in`  in  1  shadow write strobe.
- `commit_in`  in  1  request to copy the shadow taps to the active taps.
- `enable_in`  in  1  level; filter requested on.
- `hold_req_in`  in  1  external hold request.
- `filter_out_in`  in  SIGNAL_OUT_SIZE signed  filter `signal_out`.
- `rail_hi_in`, `rail_lo_in`  in  SIGNAL_OUT_SIZE signed  rail thresholds.
- `a1_out`, `b0_out`, `b1_out`  out  35 signed  active taps.
- `on_out`, `hold_out`  out  1  filter enable and hold.
- `railed_out`  out  2  [0]=at low rail, [1]=at high rail.
- `busy_out`  out  1  commit pending or UPDATE in progress.
- `commit_done_out`  out  1  one-cycle pulse when new taps are live.
- `state_out`  out  2  current state encoding.

## Operation
- States: OFF=0, PRIME=1, RUN=2, UPDATE=3.
- 5-bit down counter `cnt`.
- 1-bit `pending` flag for commits deferred from PRIME.
- **Reset:** all outputs 0, state OFF, shadow and active taps 0, `cnt`=0, `pending`=0.
- **Shadow writes:**
  - Accepted in every state when `coef_we_in`=1 and `coef_addr_in`≠3.
  - The copy reads the registered shadow value. A write in the same cycle as the copy is not included.
- **OFF:**
  - `on_out`=0, `hold_out`=0.
  - `commit_in`=1 copies shadow to active at that edge; `commit_done_out` pulses the next cycle.
  - `enable_in`=1 → PRIME, with `cnt`=SETTLE_CYCLES−1.
- **PRIME:**
  - `on_out`=1, `hold_out`=1. `cnt` decrements each cycle.
  - `cnt`=0 → RUN.
  - `commit_in` sets `pending`.
- **RUN:**
  - `on_out`=1, `hold_out`=`hold_req_in` delayed one cycle.
  - `commit_in`=1 or `pending`=1 → UPDATE, with `cnt`=SETTLE_CYCLES and `pending` cleared.
- **UPDATE:**
  - `on_out`=1, `hold_out`=1.
  - First cycle: active taps ← shadow at the ending edge.
  - `cnt` decrements each cycle. `cnt`=0 → RUN, and `commit_done_out`=1 in the first RUN cycle.
  - `commit_in` is ignored.
- **Disable:** `enable_in`=0 in any state except OFF → OFF at the next edge.
  - `pending` is cleared.
  - A commit not yet copied is dropped, with no `commit_done_out`.
  - A copy already done is kept.
- **Railed flags** (registered):
  - `railed_out[1]` = `filter_out_in` ≥ `rail_hi_in`.
  - `railed_out[0]` = `filter_out_in` ≤ `rail_lo_in`.
  - Both forced to 0 when the next `on_out`=0.
  - If `rail_lo_in` ≥ `rail_hi_in`, both bits may be set; this is passed through unchanged.
- **`busy_out`** = (state==UPDATE) | `pending`.
- All comparisons are signed.

## Timing
- `enable_in` rises at edge E (sampled high at E) → `on_out`=1 and `hold_out`=1 from E+1. PRIME lasts SETTLE_CYCLES cycles; RUN from E+1+SETTLE_CYCLES.
- `commit_in` sampled at edge C in RUN:
  - UPDATE from C+1.
  - New taps visible from C+2.
  - UPDATE lasts SETTLE_CYCLES+1 cycles; `hold_out`=1 for all of them.
  - `commit_done_out` at C+2+SETTLE_CYCLES, which is also the cycle `hold_out` follows `hold_req_in` again.
- Because `hold_out` is registered one cycle before the taps change, the filter is already holding on the swap cycle.
- Railed flags: 1-cycle latency from `filter_out_in`.
- Async reset mid-UPDATE: taps return to 0 immediately; no done pulse.

## Test plan
- **Reset then OFF commit:** write a1=0x100,0000, b0=0x40,0000, b1=−0x40,0000, then pulse `commit_in` in OFF → active taps equal those values next cycle; `commit_done_out` pulses once.
- **Start-up, SETTLE_CYCLES=4:** raise `enable_in` → `on_out`=1 and `hold_out`=1 for exactly 4 cycles, `state_out` 1→2, then `hold_out` tracks `hold_req_in` with 1-cycle lag.
- **RUN commit:** change b0 in shadow and pulse `commit_in` → `hold_out`=1 for 5 cycles, taps change on the 2nd of them, `commit_done_out` on the cycle after the last.
- **PRIME commit deferral:** pulse `commit_in` during PRIME → `busy_out`=1 until UPDATE ends; UPDATE begins the cycle after RUN entry.
- **Abort:** drop `enable_in` during the first UPDATE cycle → OFF next cycle, `on_out`=0, taps unchanged, no done pulse. Repeat with the drop in the 3rd UPDATE cycle → taps updated, no done pulse.
- **Rails:** `rail_hi_in`=1000, `rail_lo_in`=−1000; drive `filter_out_in` = 1000, 999, −1000, −1001 → `railed_out` = 10, 00, 01, 01 one cycle later; all 00 while OFF.
